// File: rtl/sonic_v1_15_nios_base_irq_ctrl.sv
// sonic_v1_15_nios_base_irq_ctrl: Avalon-MM interrupt aggregator with edge/level capture, masking and lowest-index ID.
module sonic_v1_15_nios_base_irq_ctrl #(
  parameter int NUM_IRQ = 8,
  parameter logic [15:0] EDGE_MASK = 16'h0000,
  parameter bit SYNC_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [15:0]        readdata,
  output logic               irq_out,
  output logic [3:0]         irq_id
);
  localparam logic [NUM_IRQ-1:0] EM = EDGE_MASK[NUM_IRQ-1:0];
  logic [NUM_IRQ-1:0] sync, hist, pending, enable, active, wd, w1c, w1s, pending_next;
  logic ctrl, wr;
  logic [3:0] id;
  logic [15:0] rd;
  generate
    if (SYNC_EN) begin : g_sync
      logic [NUM_IRQ-1:0] s1, s2;
      always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
          s1 <= '0;
          s2 <= '0;
        end else begin
          s1 <= irq_in;
          s2 <= s1;
        end
      assign sync = s2;
    end else begin : g_nosync
      assign sync = irq_in;
    end
  endgenerate
  assign wr  = chipselect && !write_n;
  assign wd  = writedata[NUM_IRQ-1:0];
  assign w1c = (wr && address == 3'd0) ? wd & EM : '0;
  assign w1s = (wr && address == 3'd2) ? wd & EM : '0;
  // hardware edge is ORed in after the clear so a colliding W1C loses
  assign pending_next = (EM & ((pending & ~w1c) | w1s | (sync & ~hist))) | (~EM & sync);
  assign active = pending & enable & {NUM_IRQ{ctrl}};
  always_comb begin
    id = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (active[i]) id = 4'(i);
  end
  always_comb begin
    rd = address == 3'd0 ? 16'(active) :
         address == 3'd1 ? 16'(enable) :
         address == 3'd2 ? 16'(pending) :
         address == 3'd3 ? {|active, 11'b0, id} :
         address == 3'd4 ? {15'b0, ctrl} : 16'h0000;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hist     <= '0;
      pending  <= '0;
      enable   <= '0;
      ctrl     <= 1'b0;
      irq_out  <= 1'b0;
      irq_id   <= 4'd0;
      readdata <= 16'h0000;
    end else begin
      hist     <= sync;
      pending  <= pending_next;
      if (wr && address == 3'd1) enable <= wd;
      if (wr && address == 3'd4) ctrl <= writedata[0];
      irq_out  <= |active;
      irq_id   <= id;
      readdata <= rd;
    end
endmodule
